// File: rtl/mips_mc_controller.sv
// Multicycle MIPS control unit: Moore FSM decoded from IR opcode/funct,
// driving ALU op select, datapath mux selects and write strobes.
// Memory states stall on mem_ready_i; a saturating wait counter raises a
// sticky timeout flag after MEM_TIMEOUT wait cycles.
// Optional feature: define MC_CTRL_BNE_EN to decode bne (opcode 000101).
module mips_mc_controller #(
  parameter int MEM_TIMEOUT = 255
) (
  input  logic       clk_i,
  input  logic       rstn_i,
  input  logic [5:0] opcode_i,
  input  logic [5:0] funct_i,
  input  logic       zero_i,
  input  logic       mem_ready_i,
  output logic [2:0] alu_control_o,
  output logic       alu_src_a_o,
  output logic [1:0] alu_src_b_o,
  output logic [1:0] pc_src_o,
  output logic       i_or_d_o,
  output logic       mem_to_reg_o,
  output logic       reg_dst_o,
  output logic       ir_write_o,
  output logic       pc_write_o,
  output logic       reg_write_o,
  output logic       mem_write_o,
  output logic       illegal_o,
  output logic       timeout_o,
  output logic [3:0] state_o
);

  localparam int WW = $clog2(MEM_TIMEOUT + 1);

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_J     = 6'b000010;
`ifdef MC_CTRL_BNE_EN
  localparam logic [5:0] OP_BNE   = 6'b000101;
`endif

  typedef enum logic [3:0] {
    FETCH    = 4'd0,
    DECODE   = 4'd1,
    MEMADR   = 4'd2,
    MEMREAD  = 4'd3,
    MEMWB    = 4'd4,
    MEMWRITE = 4'd5,
    EXECUTE  = 4'd6,
    ALUWB    = 4'd7,
    BRANCH   = 4'd8,
    ADDIEXEC = 4'd9,
    ADDIWB   = 4'd10,
    JUMP     = 4'd11,
    BNE      = 4'd12
  } state_t;

  state_t        state_q, state_d;
  logic [WW-1:0] wait_q;
  logic          illegal_q, timeout_q;
  logic          illegal_d;
  logic          wait_st;
  logic          funct_ok;
  logic          irw, pw, rw, mw;

  // R-type functs we can execute; anything else is trapped in DECODE
  always_comb begin
    funct_ok = 1'b0;
    case (funct_i)
      6'b100000, 6'b100010, 6'b100100, 6'b100101, 6'b101010: funct_ok = 1'b1;
      default: funct_ok = 1'b0;
    endcase
  end

  // next-state and Moore outputs; strobes gated by inputs where noted
  always_comb begin
    state_d       = state_q;
    illegal_d     = 1'b0;
    wait_st       = 1'b0;
    alu_control_o = 3'b010;
    alu_src_a_o   = 1'b0;
    alu_src_b_o   = 2'b00;
    pc_src_o      = 2'b00;
    i_or_d_o      = 1'b0;
    mem_to_reg_o  = 1'b0;
    reg_dst_o     = 1'b0;
    irw           = 1'b0;
    pw            = 1'b0;
    rw            = 1'b0;
    mw            = 1'b0;
    case (state_q)
      FETCH: begin
        alu_src_b_o = 2'b01;
        irw         = mem_ready_i;
        wait_st     = 1'b1;
        if (mem_ready_i) state_d = DECODE;
      end
      DECODE: begin
        // PC <= PC+4 from FETCH while the ALU forms the branch target
        pw          = 1'b1;
        alu_src_b_o = 2'b11;
        case (opcode_i)
          OP_RTYPE: begin
            if (funct_ok) state_d = EXECUTE;
            else begin
              state_d   = FETCH;
              illegal_d = 1'b1;
            end
          end
          OP_LW, OP_SW: state_d = MEMADR;
          OP_BEQ:       state_d = BRANCH;
          OP_ADDI:      state_d = ADDIEXEC;
          OP_J:         state_d = JUMP;
`ifdef MC_CTRL_BNE_EN
          OP_BNE:       state_d = BNE;
`endif
          default: begin
            state_d   = FETCH;
            illegal_d = 1'b1;
          end
        endcase
      end
      MEMADR: begin
        alu_src_a_o = 1'b1;
        alu_src_b_o = 2'b10;
        state_d     = (opcode_i == OP_SW) ? MEMWRITE : MEMREAD;
      end
      MEMREAD: begin
        i_or_d_o = 1'b1;
        wait_st  = 1'b1;
        if (mem_ready_i) state_d = MEMWB;
      end
      MEMWB: begin
        rw           = 1'b1;
        mem_to_reg_o = 1'b1;
        state_d      = FETCH;
      end
      MEMWRITE: begin
        i_or_d_o = 1'b1;
        mw       = 1'b1;
        wait_st  = 1'b1;
        if (mem_ready_i) state_d = FETCH;
      end
      EXECUTE: begin
        alu_src_a_o = 1'b1;
        case (funct_i)
          6'b100010: alu_control_o = 3'b110;
          6'b100100: alu_control_o = 3'b000;
          6'b100101: alu_control_o = 3'b001;
          6'b101010: alu_control_o = 3'b111;
          default:   alu_control_o = 3'b010;
        endcase
        state_d = ALUWB;
      end
      ALUWB: begin
        rw        = 1'b1;
        reg_dst_o = 1'b1;
        state_d   = FETCH;
      end
      ADDIEXEC: begin
        alu_src_a_o = 1'b1;
        alu_src_b_o = 2'b10;
        state_d     = ADDIWB;
      end
      ADDIWB: begin
        rw      = 1'b1;
        state_d = FETCH;
      end
      BRANCH: begin
        alu_src_a_o   = 1'b1;
        alu_control_o = 3'b110;
        pw            = zero_i;
        state_d       = FETCH;
      end
`ifdef MC_CTRL_BNE_EN
      BNE: begin
        alu_src_a_o   = 1'b1;
        alu_control_o = 3'b110;
        pw            = ~zero_i;
        state_d       = FETCH;
      end
`endif
      JUMP: begin
        pc_src_o = 2'b10;
        pw       = 1'b1;
        state_d  = FETCH;
      end
      default: state_d = FETCH;
    endcase
  end

  // strobes must stay quiet while reset is held, even though FETCH gates on ready
  assign ir_write_o  = irw & rstn_i;
  assign pc_write_o  = pw  & rstn_i;
  assign reg_write_o = rw  & rstn_i;
  assign mem_write_o = mw  & rstn_i;
  assign illegal_o   = illegal_q;
  assign timeout_o   = timeout_q;
  assign state_o     = state_q;

  // state register, registered illegal pulse, wait counter and sticky timeout
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      state_q   <= FETCH;
      illegal_q <= 1'b0;
      timeout_q <= 1'b0;
      wait_q    <= '0;
    end else begin
      state_q   <= state_d;
      illegal_q <= illegal_d;
      if (wait_st && !mem_ready_i) begin
        if (wait_q != WW'(MEM_TIMEOUT)) wait_q <= wait_q + 1'b1;
        // flag rises on the edge where the count reaches the limit
        if (wait_q >= WW'(MEM_TIMEOUT - 1)) timeout_q <= 1'b1;
      end else begin
        wait_q <= '0;
      end
    end
  end

endmodule

// File: tb/tb_mips_mc_controller.sv
// Scoreboard bench for mips_mc_controller: the driver pushes hand-computed
// per-cycle expectations; a negedge monitor pops and compares.
module tb_mips_mc_controller;

  logic       clk, rstn;
  logic [5:0] opcode, funct;
  logic       zero, mem_ready;
  logic [2:0] alu_control;
  logic       alu_src_a;
  logic [1:0] alu_src_b, pc_src;
  logic       i_or_d, mem_to_reg, reg_dst;
  logic       ir_write, pc_write, reg_write, mem_write;
  logic       illegal, timeout;
  logic [3:0] state;

  mips_mc_controller #(.MEM_TIMEOUT(4)) dut (
    .clk_i(clk), .rstn_i(rstn), .opcode_i(opcode), .funct_i(funct),
    .zero_i(zero), .mem_ready_i(mem_ready),
    .alu_control_o(alu_control), .alu_src_a_o(alu_src_a), .alu_src_b_o(alu_src_b),
    .pc_src_o(pc_src), .i_or_d_o(i_or_d), .mem_to_reg_o(mem_to_reg),
    .reg_dst_o(reg_dst), .ir_write_o(ir_write), .pc_write_o(pc_write),
    .reg_write_o(reg_write), .mem_write_o(mem_write), .illegal_o(illegal),
    .timeout_o(timeout), .state_o(state)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    string       nm;
    logic [20:0] v;
    logic [20:0] m;
  } exp_t;

  exp_t q[$];
  int   checks = 0;
  int   errors = 0;

  // field masks within the observed vector
  localparam logic [20:0] MA   = 21'h1C000;  // alu_control
  localparam logic [20:0] MSA  = 21'h02000;  // alu_src_a
  localparam logic [20:0] MSB  = 21'h01800;  // alu_src_b
  localparam logic [20:0] MPC  = 21'h00600;  // pc_src
  localparam logic [20:0] MIO  = 21'h00100;  // i_or_d
  localparam logic [20:0] MM2R = 21'h00080;  // mem_to_reg
  localparam logic [20:0] MRD  = 21'h00040;  // reg_dst
  localparam logic [20:0] MFIX = 21'h1E003F; // state, strobes, flags

  function automatic logic [20:0] fa(input logic [2:0] a);  return 21'(a) << 14; endfunction
  function automatic logic [20:0] fsa(input logic a);       return 21'(a) << 13; endfunction
  function automatic logic [20:0] fsb(input logic [1:0] b); return 21'(b) << 11; endfunction
  function automatic logic [20:0] fpc(input logic [1:0] p); return 21'(p) << 9;  endfunction
  function automatic logic [20:0] fio(input logic b);       return 21'(b) << 8;  endfunction
  function automatic logic [20:0] fm2r(input logic b);      return 21'(b) << 7;  endfunction
  function automatic logic [20:0] frd(input logic b);       return 21'(b) << 6;  endfunction

  logic [20:0] obs;
  assign obs = {state, alu_control, alu_src_a, alu_src_b, pc_src, i_or_d, mem_to_reg,
                reg_dst, ir_write, pc_write, reg_write, mem_write, illegal, timeout};

  // monitor: one expectation per clock cycle, sampled mid-cycle
  always @(negedge clk) begin
    if (q.size() != 0) begin
      exp_t e;
      e = q.pop_front();
      checks++;
      if ((obs & e.m) !== (e.v & e.m)) begin
        errors++;
        $display("FAIL %s: got %h required %h (mask %h)", e.nm, obs & e.m, e.v & e.m, e.m);
      end
    end
  end

  // one cycle: drive ready/zero, push expectation, advance to next posedge+1
  // strb = {ir_write, pc_write, reg_write, mem_write}, flg = {illegal, timeout}
  task automatic cyc(input string nm, input logic rdy, input logic z,
                     input logic [3:0] st, input logic [3:0] strb, input logic [1:0] flg,
                     input logic [20:0] xm, input logic [20:0] xv);
    exp_t e;
    mem_ready = rdy;
    zero      = z;
    e.nm      = nm;
    e.v       = xv;
    e.v[20:17] = st;
    e.v[5:0]  = {strb, flg};
    e.m       = xm | MFIX;
    q.push_back(e);
    @(posedge clk);
    #1;
  endtask

  task automatic fetch_decode(input string nm);
    cyc({nm, "_fetch"}, 1, 0, 4'd0, 4'b1000, 2'b00, MA | MSA | MSB | MIO, fa(3'b010) | fsb(2'b01));
    cyc({nm, "_decode"}, 1, 0, 4'd1, 4'b0100, 2'b00, MA | MSA | MSB | MPC, fa(3'b010) | fsb(2'b11));
  endtask

  initial begin
    rstn = 1'b0; opcode = '0; funct = '0; zero = 1'b0; mem_ready = 1'b1;
    @(posedge clk); #1;
    // reset: FETCH selects visible, strobes forced low despite ready
    cyc("reset", 1, 0, 4'd0, 4'b0000, 2'b00, MA | MSA | MSB | MIO | MPC, fa(3'b010) | fsb(2'b01));
    rstn = 1'b1;

    // R-type sub
    opcode = 6'b000000; funct = 6'b100010;
    fetch_decode("sub");
    cyc("sub_exec", 1, 0, 4'd6, 4'b0000, 2'b00, MA | MSA | MSB, fa(3'b110) | fsa(1) | fsb(2'b00));
    cyc("sub_aluwb", 1, 0, 4'd7, 4'b0010, 2'b00, MRD | MM2R, frd(1));

    // lw with three wait cycles
    opcode = 6'b100011; funct = 6'b000000;
    fetch_decode("lw");
    cyc("lw_memadr", 0, 0, 4'd2, 4'b0000, 2'b00, MA | MSA | MSB, fa(3'b010) | fsa(1) | fsb(2'b10));
    for (int i = 0; i < 3; i++)
      cyc("lw_memread_wait", 0, 0, 4'd3, 4'b0000, 2'b00, MIO, fio(1));
    cyc("lw_memread_done", 1, 0, 4'd3, 4'b0000, 2'b00, MIO, fio(1));
    cyc("lw_memwb", 1, 0, 4'd4, 4'b0010, 2'b00, MM2R | MRD, fm2r(1));

    // beq taken / not taken
    opcode = 6'b000100;
    fetch_decode("beq1");
    cyc("beq_taken", 1, 1, 4'd8, 4'b0100, 2'b00, MA | MSA | MSB | MPC, fa(3'b110) | fsa(1));
    fetch_decode("beq0");
    cyc("beq_not_taken", 1, 0, 4'd8, 4'b0000, 2'b00, MA | MSA | MSB | MPC, fa(3'b110) | fsa(1));

    // addi
    opcode = 6'b001000;
    fetch_decode("addi");
    cyc("addi_exec", 1, 0, 4'd9, 4'b0000, 2'b00, MA | MSA | MSB, fa(3'b010) | fsa(1) | fsb(2'b10));
    cyc("addi_wb", 1, 0, 4'd10, 4'b0010, 2'b00, MRD | MM2R, 21'h0);

    // j
    opcode = 6'b000010;
    fetch_decode("j");
    cyc("j_jump", 1, 0, 4'd11, 4'b0100, 2'b00, MPC, fpc(2'b10));

    // bne
    opcode = 6'b000101;
    fetch_decode("bne");
`ifdef MC_CTRL_BNE_EN
    cyc("bne_taken", 1, 0, 4'd12, 4'b0100, 2'b00, MA | MSA | MPC, fa(3'b110) | fsa(1));
    fetch_decode("bne_z1");
    cyc("bne_not_taken", 1, 1, 4'd12, 4'b0000, 2'b00, MA | MSA | MPC, fa(3'b110) | fsa(1));
`else
    cyc("bne_illegal", 0, 0, 4'd0, 4'b0000, 2'b10, 21'h0, 21'h0);
`endif

    // illegal opcode: pulse lasts exactly one cycle
    opcode = 6'b111111;
    fetch_decode("badop");
    cyc("badop_illegal", 0, 0, 4'd0, 4'b0000, 2'b10, 21'h0, 21'h0);
    // illegal funct
    opcode = 6'b000000; funct = 6'b000001;
    cyc("badop_pulse_end", 1, 0, 4'd0, 4'b1000, 2'b00, 21'h0, 21'h0);
    cyc("badfn_decode", 1, 0, 4'd1, 4'b0100, 2'b00, 21'h0, 21'h0);
    cyc("badfn_illegal", 0, 0, 4'd0, 4'b0000, 2'b10, 21'h0, 21'h0);

    // sw with 10 wait cycles: timeout after the 4th, write held throughout
    opcode = 6'b101011; funct = 6'b000000;
    fetch_decode("sw");
    cyc("sw_memadr", 0, 0, 4'd2, 4'b0000, 2'b00, MSA | MSB, fsa(1) | fsb(2'b10));
    for (int i = 1; i <= 10; i++)
      cyc((i <= 4) ? "sw_wait_pre_timeout" : "sw_wait_timeout", 0, 0, 4'd5, 4'b0001,
          (i <= 4) ? 2'b00 : 2'b01, MIO, fio(1));
    cyc("sw_done", 1, 0, 4'd5, 4'b0001, 2'b01, MIO, fio(1));
    cyc("sticky_fetch", 1, 0, 4'd0, 4'b1000, 2'b01, 21'h0, 21'h0);
    cyc("sticky_decode", 1, 0, 4'd1, 4'b0100, 2'b01, 21'h0, 21'h0);
    cyc("sw2_memadr", 1, 0, 4'd2, 4'b0000, 2'b01, 21'h0, 21'h0);
    cyc("sw2_memwrite", 0, 0, 4'd5, 4'b0001, 2'b01, MIO, fio(1));

    // async reset mid-MEMWRITE
    rstn = 1'b0;
    cyc("reset_mid", 0, 0, 4'd0, 4'b0000, 2'b00, MA | MSB | MIO, fa(3'b010) | fsb(2'b01));
    rstn = 1'b1;
    cyc("post_reset_fetch", 1, 0, 4'd0, 4'b1000, 2'b00, MA | MSB, fa(3'b010) | fsb(2'b01));

    repeat (2) @(posedge clk);
    if (q.size() != 0) begin
      errors++;
      $display("FAIL drain: %0d expectations left, required 0", q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
